morse_letter_checker: RTL

Consumes the five latched Morse symbols and the letter-done flag from the button-to-Morse stage, decodes them to a letter index and grades the attempt against a pseudo-randomly chosen target letter. Sits directly downstream of button entry and upstream of the display and LED drivers. Outputs are the prompt letter, the decoded letter, per-attempt correct/wrong flags held for a display window, and saturating score counters.

---
 rtl/morse_letter_checker.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/morse_letter_checker.sv
// Morse trainer grading stage: decodes five latched symbols, grades them against an LFSR-chosen target.
// Build option: define DIGITS_EN to decode the 5-symbol digits 0-9 and widen the target pool to 36.
module morse_letter_checker #(
    parameter int HOLD_CYCLES = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             morse_one,
    input  logic [1:0]             morse_two,
    input  logic [1:0]             morse_three,
    input  logic [1:0]             morse_four,
    input  logic [1:0]             morse_five,
    input  logic                   letter_done,
    output logic [5:0]             target_letter,
    output logic                   target_valid,
    output logic [5:0]             decoded_letter,
    output logic                   decode_valid,
    output logic                   result_correct,
    output logic                   result_wrong,
    output logic [COUNT_WIDTH-1:0] correct_count,
    output logic [COUNT_WIDTH-1:0] attempt_count,
    output logic [COUNT_WIDTH-1:0] streak
);

`ifdef DIGITS_EN
    localparam int POOL = 36;
`else
    localparam int POOL = 26;
`endif
    localparam logic [5:0]             INVALID     = 6'h3F;
    localparam int                     HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]      HOLD_LOAD   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [7:0]             LFSR_SEED   = 8'hA5;
    localparam logic [5:0]             SEED_TARGET = 6'(LFSR_SEED % 8'(POOL));
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {IDLE, DECODE, CHECK, HOLD, NEXT} state_t;

    state_t            state;
    logic              letter_done_q;
    logic [9:0]        symbols;
    logic [HOLD_W-1:0] hold_cnt;
    logic              last_correct;
    logic [7:0]        lfsr;
    logic [5:0]        candidate;
    logic              accept;
    logic              is_match;

    // Exact whole-pattern match: gaps, 2'b11 symbols and all-empty never hit a
    // listed entry, so they fall through to INVALID without a separate check.
    function automatic logic [5:0] decode_symbols(input logic [9:0] s);
        logic [5:0] code;
        code = INVALID;
        case (s)
            10'b01_10_00_00_00: code = 6'd0;
            10'b10_01_01_01_00: code = 6'd1;
            10'b10_01_10_01_00: code = 6'd2;
            10'b10_01_01_00_00: code = 6'd3;
            10'b01_00_00_00_00: code = 6'd4;
            10'b01_01_10_01_00: code = 6'd5;
            10'b10_10_01_00_00: code = 6'd6;
            10'b01_01_01_01_00: code = 6'd7;
            10'b01_01_00_00_00: code = 6'd8;
            10'b01_10_10_10_00: code = 6'd9;
            10'b10_01_10_00_00: code = 6'd10;
            10'b01_10_01_01_00: code = 6'd11;
            10'b10_10_00_00_00: code = 6'd12;
            10'b10_01_00_00_00: code = 6'd13;
            10'b10_10_10_00_00: code = 6'd14;
            10'b01_10_10_01_00: code = 6'd15;
            10'b10_10_01_10_00: code = 6'd16;
            10'b01_10_01_00_00: code = 6'd17;
            10'b01_01_01_00_00: code = 6'd18;
            10'b10_00_00_00_00: code = 6'd19;
            10'b01_01_10_00_00: code = 6'd20;
            10'b01_01_01_10_00: code = 6'd21;
            10'b01_10_10_00_00: code = 6'd22;
            10'b10_01_01_10_00: code = 6'd23;
            10'b10_01_10_10_00: code = 6'd24;
            10'b10_10_01_01_00: code = 6'd25;
`ifdef DIGITS_EN
            10'b10_10_10_10_10: code = 6'd26;
            10'b01_10_10_10_10: code = 6'd27;
            10'b01_01_10_10_10: code = 6'd28;
            10'b01_01_01_10_10: code = 6'd29;
            10'b01_01_01_01_10: code = 6'd30;
            10'b01_01_01_01_01: code = 6'd31;
            10'b10_01_01_01_01: code = 6'd32;
            10'b10_10_01_01_01: code = 6'd33;
            10'b10_10_10_01_01: code = 6'd34;
            10'b10_10_10_10_01: code = 6'd35;
`endif
            default:            code = INVALID;
        endcase
        return code;
    endfunction

    assign candidate = 6'(lfsr % 8'(POOL));
    assign accept    = letter_done & ~letter_done_q & (state == IDLE);
    // Target is always < POOL, so INVALID can never match.
    assign is_match  = (decoded_letter == target_letter);

    // Fibonacci LFSR, taps 8,6,5,4; free-running so the next target depends on user timing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            letter_done_q  <= 1'b0;
            symbols        <= '0;
            hold_cnt       <= '0;
            last_correct   <= 1'b0;
            target_letter  <= SEED_TARGET;
            target_valid   <= 1'b1;
            decoded_letter <= INVALID;
            decode_valid   <= 1'b0;
            result_correct <= 1'b0;
            result_wrong   <= 1'b0;
            correct_count  <= '0;
            attempt_count  <= '0;
            streak         <= '0;
        end else begin
            letter_done_q <= letter_done;
            decode_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        symbols      <= {morse_one, morse_two, morse_three, morse_four, morse_five};
                        target_valid <= 1'b0;
                        state        <= DECODE;
                    end
                end
                DECODE: begin
                    decoded_letter <= decode_symbols(symbols);
                    decode_valid   <= 1'b1;
                    state          <= CHECK;
                end
                CHECK: begin
                    if (attempt_count != CNT_MAX) attempt_count <= attempt_count + 1'b1;
                    if (is_match) begin
                        result_correct <= 1'b1;
                        last_correct   <= 1'b1;
                        if (correct_count != CNT_MAX) correct_count <= correct_count + 1'b1;
                        if (streak != CNT_MAX)        streak        <= streak + 1'b1;
                    end else begin
                        result_wrong <= 1'b1;
                        last_correct <= 1'b0;
                        streak       <= '0;
                    end
                    hold_cnt <= HOLD_LOAD;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        result_correct <= 1'b0;
                        result_wrong   <= 1'b0;
                        state          <= NEXT;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                NEXT: begin
                    // A wrong attempt keeps the same prompt so the user retries it.
                    if (last_correct) target_letter <= candidate;
                    target_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
